fetch: RTL and testbench
========================

# fetch

Instruction-fetch stage: owns the architectural PC, issues one instruction-bus request at a time and holds the returned instruction in a one-entry buffer. The buffer drives `fetch_data_t` (`pc`, `raw_instr`) into the decode stage directly downstream through a valid/ready handshake. Redirects from later stages (branch/jump resolution) override the PC, including while a bus request is outstanding.

## Interface
Parameters:
- `PC_RESET`, default 64'h8000_0000: PC value after reset.

Ports:
- `clk`  in  1  clock. One clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `ireq`  out  `ibus_req_t`  `valid`, `addr[63:0]`.
- `iresp`  in  `ibus_resp_t`  `data_ok`, `data[31:0]`.
- `redirect_valid`  in  1  replace PC this cycle.
- `redirect_pc`  in  64  target PC.
- `readyD`  in  1  decode accepts `dataF` this cycle.
- `validF`  out  1  `dataF` holds a valid instruction.
- `dataF`  out  `fetch_data_t`  `pc[63:0]`, `raw_instr[31:0]`.
- `misalignF`  out  1  the held entry is a misaligned-PC fault.

## Operation
- Registers: `pc`, state, buffer (`pc`, `instr`, `misalign`).
- States:
  - REQ: `ireq.valid=1`, `ireq.addr=pc`.
  - HOLD: buffer valid, `validF=1`.
  - DISCARD: request outstanding, result to be dropped.
- Bus rule: once `ireq.valid` is asserted, `valid` and `addr` stay stable until `data_ok`. No second request is issued before `data_ok`.
- Transitions, in priority order:
  - REQ, `redirect_valid`, `data_ok`: drop data, `pc<=redirect_pc`, stay REQ.
  - REQ, `redirect_valid`, no `data_ok`: `pc<=redirect_pc`, go DISCARD. Address stays at the old PC until `data_ok`.
  - REQ, `data_ok`: buffer `{pc, data}`, go HOLD.
  - HOLD, `redirect_valid`: invalidate buffer, `pc<=redirect_pc`, go REQ. Redirect wins over a simultaneous accept; the instruction is not delivered.
  - HOLD, `readyD`: transfer. `pc<=pc+4` (64-bit wrap, carry discarded), go REQ.
  - DISCARD, `redirect_valid`: `pc<=redirect_pc` (last redirect wins). If `data_ok` in the same cycle, go REQ; otherwise stay DISCARD.
  - DISCARD, `data_ok`: drop data, go REQ.
- `validF=1` only in HOLD. `dataF` is registered, never combinational from `iresp`.
- Reset values: state REQ, `pc=PC_RESET`, `validF=0`, `dataF='0`, `misalignF=0`.
- `ireq.valid` is 0 while `reset` is high and goes to 1 in the first cycle after release.
- Reset mid-request abandons the transaction. The memory side is reset by the same signal.

## Timing
- Request visible in cycle t; `data_ok` in cycle t+k (k≥0, same-cycle allowed); `validF` rises at t+k+1.
- Accept in cycle a: next request is issued in a+1 with `pc+4`. Peak throughput: one instruction per 2 cycles at k=0.
- Redirect in cycle r:
  - From REQ with `data_ok` or from HOLD: request to `redirect_pc` in r+1.
  - From DISCARD: the new request is issued one cycle after the stale `data_ok`.
- A stalled HOLD (`readyD=0`) keeps `dataF` and `validF` unchanged indefinitely.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - In REQ with `pc[1:0]!=0`: no bus request (`ireq.valid=0`). Go HOLD next cycle with `raw_instr=0`, `misalignF=1`.
  - Redirect and accept rules are unchanged.
- `FETCH_ALIGN_CHECK_EN` undefined: no check. `misalignF` is tied 0; `pc[1:0]` is passed to the bus unchanged.

## Structure
- `pipes` package: `fetch_state_t` enum (REQ, HOLD, DISCARD). `fetch_data_t` stays there.
- `common` package: `ibus_req_t`, `ibus_resp_t`, and the `PC_RESET` default constant.
- One sub-module, `pcselect`: combinational next-PC mux (redirect / pc+4 / hold). The FSM and registers stay in `fetch`.

## Test plan
- Reset: `PC_RESET=64'h8000_0000`, memory k=0, `readyD=1` → requests to 8000_0000, 8000_0004, 8000_0008 on alternating cycles; `dataF.pc` matches each request; `validF=0` during reset.
- Stall: memory returns 32'h0010_0093; hold `readyD=0` for 5 cycles → `validF=1`, `dataF` constant for all 5. The next request is to pc+4 only after `readyD=1`.
- Redirect mid-request: k=3, redirect to 8000_0100 one cycle after the request → `ireq.addr` stays 8000_0000 until `data_ok`; that data is never delivered; the next request is to 8000_0100.
- Redirect in HOLD with `readyD=1` in the same cycle → no transfer (decode sees no accept); the next request is to the redirect target.
- Double redirect in DISCARD (8000_0200, then 8000_0300) → the next request is to 8000_0300.
- Misaligned PC with `FETCH_ALIGN_CHECK_EN`: redirect to 8000_0002 → no `ireq.valid`; `validF=1`, `misalignF=1`, `dataF.pc=8000_0002`, `raw_instr=0`.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared bus types (common) and pipeline types (pipes) for the fetch stage
package common;

  localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

package pipes;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
  } fetch_data_t;

endpackage

// File: rtl/fetch_pcselect.sv
// rtl/fetch_pcselect.sv - next-PC mux: redirect target, sequential pc+4, or hold
module pcselect (
  input  logic [63:0] pc_i,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  input  logic        advance_i,
  output logic [63:0] pc_o
);

  // Redirect always wins; advancing wraps naturally at 64 bits.
  always_comb begin
    pc_o = pc_i;
    if (redirect_valid_i) begin
      pc_o = redirect_pc_i;
    end else if (advance_i) begin
      pc_o = pc_i + 64'd4;
    end
  end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage; optional misaligned-PC fault via FETCH_ALIGN_CHECK_EN
module fetch
  import common::*;
  import pipes::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        readyD,
  output logic        validF,
  output fetch_data_t dataF,
  output logic        misalignF
);

  fetch_state_t state_q;
  logic [63:0]  pc_q;
  logic [63:0]  pc_d;
  logic [63:0]  req_addr_q;
  fetch_data_t  buf_q;
  logic         buf_mis_q;

  logic misaligned;
  logic req_done;
  logic accept;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (state_q == REQ) && (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned PC completes locally without touching the bus.
  assign req_done = iresp.data_ok || misaligned;
  // Redirect overrides a simultaneous accept, so the entry is not consumed.
  assign accept   = (state_q == HOLD) && readyD && !redirect_valid;

  pcselect u_pcselect (
    .pc_i             (pc_q),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .advance_i        (accept),
    .pc_o             (pc_d)
  );

  // DISCARD keeps presenting the abandoned address until the bus answers.
  assign ireq.valid = !reset && ((state_q == DISCARD) || ((state_q == REQ) && !misaligned));
  assign ireq.addr  = (state_q == DISCARD) ? req_addr_q : pc_q;

  assign validF    = (state_q == HOLD);
  assign dataF     = buf_q;
  assign misalignF = buf_mis_q;

  // Fetch FSM together with the PC and the one-entry instruction buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= REQ;
      pc_q       <= PC_RESET;
      req_addr_q <= '0;
      buf_q      <= '0;
      buf_mis_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        REQ: begin
          if (redirect_valid) begin
            if (!req_done) begin
              state_q    <= DISCARD;
              req_addr_q <= pc_q;
            end
          end else if (req_done) begin
            state_q         <= HOLD;
            buf_q.pc        <= pc_q;
            buf_q.raw_instr <= misaligned ? 32'h0 : iresp.data;
            buf_mis_q       <= misaligned;
          end
        end
        HOLD: begin
          if (redirect_valid || readyD) begin
            state_q <= REQ;
          end
        end
        DISCARD: begin
          if (iresp.data_ok) begin
            state_q <= REQ;
          end
        end
        default: state_q <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - self-checking bench for fetch with a behavioural PC/bus model
module tb_fetch;
  import common::*;
  import pipes::*;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  ibus_req_t   ireq;
  ibus_resp_t  iresp = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        readyD = 1'b0;
  logic        validF;
  fetch_data_t dataF;
  logic        misalignF;

  int errors = 0;
  int checks = 0;
  int mem_k = 0;
  int cyc = 0;

  logic [63:0] req_log[$];
  int          req_cyc[$];
  logic [63:0] acc_log[$];

  fetch #(.PC_RESET(64'h8000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .readyD         (readyD),
    .validF         (validF),
    .dataF          (dataF),
    .misalignF      (misalignF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0010_0093;
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [63:0] req_at(input int i);
    return (i < req_log.size()) ? req_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [63:0] acc_at(input int i);
    return (i < acc_log.size()) ? acc_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: answers each request mem_k cycles after it first appears.
  int  mem_cnt = 0;
  bit  mem_busy = 1'b0;
  always @(posedge clk) begin
    #2;
    if (reset) begin
      mem_busy = 1'b0;
      iresp = '0;
    end else if (ireq.valid) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = mem_k;
      end
      if (mem_cnt == 0) begin
        iresp.data_ok = 1'b1;
        iresp.data    = mem_word(ireq.addr);
        mem_busy      = 1'b0;
      end else begin
        iresp.data_ok = 1'b0;
        mem_cnt--;
      end
    end else begin
      iresp.data_ok = 1'b0;
    end
  end

  // Architectural model: tracks the PC decode must see next and checks bus/output rules.
  logic [63:0] model_pc = 64'h8000_0000;
  logic        prev_valid = 1'b0;
  logic        prev_ok = 1'b0;
  logic [63:0] prev_addr = '0;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("rst_validF", {63'd0, validF}, 64'd0);
      chk("rst_ireq_valid", {63'd0, ireq.valid}, 64'd0);
      chk("rst_dataF_pc", dataF.pc, 64'd0);
      chk("rst_misalignF", {63'd0, misalignF}, 64'd0);
      model_pc   = 64'h8000_0000;
      prev_valid = 1'b0;
      prev_ok    = 1'b0;
      req_log.delete();
      req_cyc.delete();
      acc_log.delete();
    end else begin
      if (prev_valid && !prev_ok) begin
        chk("bus_hold_valid", {63'd0, ireq.valid}, 64'd1);
        chk("bus_hold_addr", ireq.addr, prev_addr);
      end else if (ireq.valid) begin
        chk("req_addr", ireq.addr, model_pc);
        req_log.push_back(ireq.addr);
        req_cyc.push_back(cyc);
      end
      if (validF) begin
        chk("dataF_pc", dataF.pc, model_pc);
        chk("dataF_instr", {32'd0, dataF.raw_instr},
            {32'd0, (ALIGN && model_pc[1:0] != 2'b00) ? 32'd0 : mem_word(model_pc)});
        if (ALIGN) chk("misalignF", {63'd0, misalignF}, {63'd0, model_pc[1:0] != 2'b00});
      end
      if (!ALIGN) chk("misalignF_tied", {63'd0, misalignF}, 64'd0);
      if (validF && readyD && !redirect_valid) acc_log.push_back(dataF.pc);
      prev_valid = ireq.valid;
      prev_addr  = ireq.addr;
      prev_ok    = iresp.data_ok;
      if (redirect_valid) model_pc = redirect_pc;
      else if (validF && readyD) model_pc = model_pc + 64'd4;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int k, input logic rdy);
    tick();
    reset = 1'b1;
    redirect_valid = 1'b0;
    readyD = rdy;
    mem_k = k;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic redirect_now(input logic [63:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and streaming at k=0 with decode always ready.
    do_reset(0, 1'b1);
    repeat (6) tick();
    chk("t1_req0", req_at(0), 64'h8000_0000);
    chk("t1_req1", req_at(1), 64'h8000_0004);
    chk("t1_req2", req_at(2), 64'h8000_0008);
    chk("t1_acc0", acc_at(0), 64'h8000_0000);
    chk("t1_acc1", acc_at(1), 64'h8000_0004);
    chk("t1_spacing", 64'(req_cyc.size() > 1 ? req_cyc[1] - req_cyc[0] : -1), 64'd2);

    // Stall: HOLD kept for five cycles, next request only after accept.
    do_reset(0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_validF", {63'd0, validF}, 64'd1);
      chk("t2_instr", {32'd0, dataF.raw_instr}, 64'h0010_0093);
      chk("t2_pc", dataF.pc, 64'h8000_0000);
      chk("t2_no_req", {63'd0, ireq.valid}, 64'd0);
      tick();
    end
    readyD = 1'b1;
    tick();
    readyD = 1'b0;
    tick();
    chk("t2_next_req", req_at(1), 64'h8000_0004);
    chk("t2_next_cyc", 64'(req_cyc.size() > 1 ? req_cyc[1] - req_cyc[0] : -1), 64'd7);

    // Redirect one cycle into a k=3 request.
    do_reset(3, 1'b1);
    tick();
    redirect_now(64'h8000_0100);
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    chk("t3_req0", req_at(0), 64'h8000_0000);
    chk("t3_req1", req_at(1), 64'h8000_0100);
    chk("t3_acc0", acc_at(0), 64'h8000_0100);

    // Redirect in HOLD with a simultaneous ready: no transfer.
    do_reset(0, 1'b0);
    tick();
    readyD = 1'b1;
    redirect_now(64'h8000_0040);
    tick();
    redirect_valid = 1'b0;
    readyD = 1'b0;
    repeat (4) tick();
    chk("t4_no_accept", 64'(acc_log.size()), 64'd0);
    chk("t4_req1", req_at(1), 64'h8000_0040);
    chk("t4_held_pc", dataF.pc, 64'h8000_0040);

    // Two redirects while discarding: the last one wins.
    do_reset(4, 1'b1);
    tick();
    redirect_now(64'h8000_0200);
    tick();
    redirect_now(64'h8000_0300);
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    chk("t5_req1", req_at(1), 64'h8000_0300);
    chk("t5_acc0", acc_at(0), 64'h8000_0300);

    // Redirect in REQ coinciding with data_ok: data dropped, new request next cycle.
    do_reset(0, 1'b0);
    redirect_now(64'h8000_0500);
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("t6_req_count", 64'(req_log.size()), 64'd2);
    chk("t6_req1", req_at(1), 64'h8000_0500);
    repeat (2) tick();
    chk("t6_validF", {63'd0, validF}, 64'd1);
    chk("t6_pc", dataF.pc, 64'h8000_0500);

    // PC wrap at the top of the address space.
    do_reset(0, 1'b1);
    redirect_now(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    repeat (4) tick();
    chk("t7_acc0", acc_at(0), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t7_wrap_req", req_at(2), 64'h0);

    // Misaligned redirect target.
    do_reset(0, 1'b0);
    redirect_now(64'h8000_0002);
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    chk("t8_validF", {63'd0, validF}, 64'd1);
    chk("t8_pc", dataF.pc, 64'h8000_0002);
    if (ALIGN) begin
      chk("t8_misalignF", {63'd0, misalignF}, 64'd1);
      chk("t8_instr", {32'd0, dataF.raw_instr}, 64'd0);
      chk("t8_no_bus_req", 64'(req_log.size()), 64'd1);
    end else begin
      chk("t8_misalignF", {63'd0, misalignF}, 64'd0);
      chk("t8_bus_addr", req_at(1), 64'h8000_0002);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
